imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequences the word-addressed synchronous instruction memory for the MUSA core.
- Owns the memory port in two phases:
  - LOAD: a program loader streams words into memory with an auto-incrementing address.
  - RUN: the block fetches sequentially from the PC into a small buffer and hands instructions to the core over a valid/ready interface.
- Supports branch redirect and halt.

Parameters:
- ADDR_WIDTH, 13, word address width of instruction memory.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after LOAD completes.
- BUF_DEPTH, 4, fetch buffer entries (power of 2, >=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  block accepts loader word.
- ld_data  in  DATA_WIDTH  word to store.
- ld_last  in  1  final word of program (qualified by handshake).
- load_req  in  1  re-enter LOAD from HALT.
- load_ovf  out  1  sticky: loader pointer wrapped.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_rd_en  out  1  read strobe; mem_rdata valid next cycle.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rdata  in  DATA_WIDTH  read data, 1-cycle latency.
- if_valid  out  1  instruction available to core.
- if_ready  in  1  core accepts instruction.
- if_instr  out  DATA_WIDTH  instruction.
- if_pc  out  ADDR_WIDTH  word address of if_instr.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- halt_req  in  1  stop fetching.
- state_o  out  2  current state, for debug.
- perf_fetch_cnt  out  32  instructions delivered (optional feature).
- perf_empty_cnt  out  32  RUN cycles with empty buffer (optional feature).

Behaviour:
- Reset:
  - state=S_LOAD, ld_ptr=0, pc=RESET_PC.
  - Buffer empty, no read in flight, load_ovf=0.
  - All outputs 0 except ld_ready=1 (LOAD state) and state_o=S_LOAD.
  - Reset mid-operation discards buffer, in-flight read and counters immediately.
- States: S_LOAD=0, S_RUN=1, S_HALT=2.
- S_LOAD:
  - ld_ready=1.
  - mem_wr_en=ld_valid, mem_addr=ld_ptr, mem_wdata=ld_data (combinational).
  - Each handshake increments ld_ptr modulo 2^ADDR_WIDTH.
  - A wrap from all-ones to 0 sets load_ovf (cleared only by reset).
  - Handshake with ld_last -> S_RUN next cycle, pc=RESET_PC.
  - mem_rd_en=0 and if_valid=0 throughout.
- S_RUN:
  - ld_ready=0. Issue a read when (buf_count + inflight) < BUF_DEPTH and no redirect/halt this cycle.
  - Issue drives mem_rd_en=1, mem_addr=pc; pc<=pc+1, wrapping modulo 2^ADDR_WIDTH.
  - Response is written to the buffer at the end of the following cycle, tagged with its address.
  - Latency: first if_valid 2 cycles after entering S_RUN.
  - Steady state: 1 instruction/cycle while if_ready=1.
  - if_valid = buffer not empty. if_instr/if_pc come from the head entry and are held stable while if_valid && !if_ready.
- Redirect (S_RUN only):
  - A coincident if handshake still counts as consumed.
  - Then the buffer is flushed, any in-flight response is discarded, and pc<=redirect_pc.
  - No read is issued in the redirect cycle. The next read at redirect_pc is issued the following cycle; if_valid for it follows 2 cycles later.
- halt_req in S_RUN:
  - Same flush/discard as redirect, then -> S_HALT. redirect_valid in the same cycle is ignored.
- S_HALT:
  - No memory access, if_valid=0.
  - load_req -> S_LOAD with ld_ptr=0; load_ovf unchanged.
  - halt_req, redirect_valid and ld_valid are ignored.
- Buffer full: no issue. Buffer empty: if_valid=0. Simultaneous push and pop on a full buffer cannot occur, because issue was credit-blocked.

Optional Feature:
- IMEM_PERF_CNT_EN defined:
  - perf_fetch_cnt increments on each if_valid && if_ready.
  - perf_empty_cnt increments each S_RUN cycle with an empty buffer.
  - Both counters saturate at 2^32-1 and are zeroed by reset or on entering S_LOAD.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package imem_ctrl_pkg:
  - state enum (S_LOAD/S_RUN/S_HALT) and its 2-bit encoding.
  - Buffer entry typedef {pc, instr}.
  - Counter width constant.
- One natural sub-module: imem_fetch_buf, a synchronous FIFO of BUF_DEPTH entries with push/pop/flush, count, full and empty.

Test Plan:
- Load 6 words 0x0..0x5, ld_last on word 6 -> mem writes at addresses 0..5, state_o=1 next cycle, first if_valid 2 cycles later, if_pc=0, if_instr=word0.
- RUN with if_ready=1 for 10 cycles -> if_pc 0,1,2,... one per cycle with no bubbles.
- if_ready=0 for 8 cycles -> at most BUF_DEPTH reads issued; if_instr/if_pc held; release if_ready -> in-order delivery with no loss or duplicates.
- redirect_valid with redirect_pc=0x100 while 2 entries buffered and 1 read in flight -> old entries never appear; next read at 0x100 issued the following cycle; next if_pc=0x100.
- halt_req mid-stream -> if_valid=0 next cycle and S_HALT; load_req -> S_LOAD with ld_ptr=0. Assert rst_n low mid-RUN -> all outputs reset immediately.
- With IMEM_PERF_CNT_EN: deliver 5 instructions with 3 empty RUN cycles -> perf_fetch_cnt=5, perf_empty_cnt=3. Without the macro -> both read 0.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types for the instruction-memory fetch controller: state encoding,
// fetch-buffer entry layout and the performance-counter width.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } imem_state_e;

    localparam int IMEM_ADDR_W = 13;
    localparam int IMEM_DATA_W = 32;
    localparam int PERF_CNT_W  = 32;

    // Buffer entries are packed {pc, instr}, pc in the upper bits.
    typedef struct packed {
        logic [IMEM_ADDR_W-1:0] pc;
        logic [IMEM_DATA_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == '1) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/imem_fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; flush empties it
// in one cycle and takes priority over push/pop.
module imem_fetch_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 45
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] entry_data [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    entry_reg <= '0;
                else if (do_push && wr_ptr_reg == PW'(gi))
                    entry_reg <= push_data;
            end
            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = entry_data[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: program LOAD phase, then sequential RUN fetch
// into a buffer with redirect/halt. IMEM_PERF_CNT_EN adds delivery/empty counters.
module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    input  logic                  load_req,
    output logic                  load_ovf,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic [1:0]            state_o,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_empty_cnt
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    imem_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ld_ptr_reg, ld_ptr_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDR_WIDTH-1:0] inflight_pc_reg, inflight_pc_next;
    logic                  inflight_reg, inflight_next;
    logic                  load_ovf_reg, load_ovf_next;

    logic          buf_push, buf_flush, buf_full, buf_empty, if_fire;
    logic [CW-1:0] buf_count, occupancy;
    logic [EW-1:0] head_data;

    assign occupancy = buf_count + CW'(inflight_reg);
    assign if_valid  = !buf_empty;
    assign if_fire   = if_valid && if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_LOAD;
            ld_ptr_reg      <= '0;
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            load_ovf_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ld_ptr_reg      <= ld_ptr_next;
            pc_reg          <= pc_next;
            inflight_pc_reg <= inflight_pc_next;
            inflight_reg    <= inflight_next;
            load_ovf_reg    <= load_ovf_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        ld_ptr_next      = ld_ptr_reg;
        pc_next          = pc_reg;
        inflight_pc_next = inflight_pc_reg;
        inflight_next    = inflight_reg;
        load_ovf_next    = load_ovf_reg;
        ld_ready         = 1'b0;
        mem_addr         = '0;
        mem_rd_en        = 1'b0;
        mem_wr_en        = 1'b0;
        mem_wdata        = '0;
        buf_push         = 1'b0;
        buf_flush        = 1'b0;
        case (state_reg)
            S_LOAD: begin
                ld_ready  = 1'b1;
                mem_wr_en = ld_valid;
                mem_addr  = ld_ptr_reg;
                mem_wdata = ld_data;
                if (ld_valid) begin
                    ld_ptr_next = ld_ptr_reg + ADDR_WIDTH'(1);
                    if (ld_ptr_reg == '1)
                        load_ovf_next = 1'b1;
                    if (ld_last) begin
                        state_next = S_RUN;
                        pc_next    = RESET_PC;
                    end
                end
            end
            S_RUN: begin
                if (halt_req || redirect_valid) begin
                    // The response of the read issued last cycle is dropped here.
                    buf_flush     = 1'b1;
                    inflight_next = 1'b0;
                    if (halt_req)
                        state_next = S_HALT;
                    else
                        pc_next = redirect_pc;
                end else begin
                    buf_push      = inflight_reg;
                    inflight_next = 1'b0;
                    if (occupancy < CW'(BUF_DEPTH)) begin
                        mem_rd_en        = 1'b1;
                        mem_addr         = pc_reg;
                        pc_next          = pc_reg + ADDR_WIDTH'(1);
                        inflight_next    = 1'b1;
                        inflight_pc_next = pc_reg;
                    end
                end
            end
            S_HALT: begin
                if (load_req) begin
                    state_next  = S_LOAD;
                    ld_ptr_next = '0;
                end
            end
            default: state_next = S_LOAD;
        endcase
    end

    imem_fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (EW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .pop       (if_fire),
        .flush     (buf_flush),
        .push_data ({inflight_pc_reg, mem_rdata}),
        .head_data (head_data),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign if_instr = buf_empty ? '0 : head_data[DATA_WIDTH-1:0];
    assign if_pc    = buf_empty ? '0 : head_data[EW-1:DATA_WIDTH];
    assign load_ovf = load_ovf_reg;
    assign state_o  = state_reg;

`ifdef IMEM_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] perf_fetch_reg, perf_empty_reg;
    logic                  enter_load;

    assign enter_load = (state_next == S_LOAD) && (state_reg != S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_reg <= '0;
            perf_empty_reg <= '0;
        end else if (enter_load) begin
            perf_fetch_reg <= '0;
            perf_empty_reg <= '0;
        end else begin
            if (if_fire)
                perf_fetch_reg <= sat_inc(perf_fetch_reg);
            if (state_reg == S_RUN && buf_empty)
                perf_empty_reg <= sat_inc(perf_empty_reg);
        end
    end

    assign perf_fetch_cnt = perf_fetch_reg;
    assign perf_empty_cnt = perf_empty_reg;
`else
    assign perf_fetch_cnt = '0;
    assign perf_empty_cnt = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural 1-cycle-latency memory;
// covers load, streaming, stall, redirect, halt, reset, perf counters and load wrap.
module tb_imem_fetch_ctrl;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_valid = 1'b0, ld_last = 1'b0, load_req = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          if_ready = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          ld_ready, load_ovf, mem_rd_en, mem_wr_en, if_valid;
    logic [AW-1:0] mem_addr, if_pc;
    logic [DW-1:0] mem_wdata, mem_rdata, if_instr;
    logic [1:0]    state_o;
    logic [31:0]   perf_fetch_cnt, perf_empty_cnt;

    logic [DW-1:0] imem [2**AW];
    int            rd_cnt = 0;
    int            checks_total = 0;
    int            checks_passed = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   ('0),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .load_req       (load_req),
        .load_ovf       (load_ovf),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_wr_en      (mem_wr_en),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .state_o        (state_o),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_empty_cnt (perf_empty_cnt)
    );

    always @(posedge clk) begin
        if (mem_wr_en) imem[mem_addr] <= mem_wdata;
        if (mem_rd_en) begin
            mem_rdata <= imem[mem_addr];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready)
            $display("deliver pc=0x%04h instr=0x%08h", if_pc, if_instr);
    end

    // Program words 0..5 hold 0xC0DE0000+addr; everything else keeps its prefill.
    function automatic logic [DW-1:0] exp_instr(input int a);
        return (a < 6) ? (32'hC0DE_0000 + 32'(a)) : (32'hA000_0000 + 32'(a));
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs !== exp)
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            checks_passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hC0DE_0000 + 32'(i);
            ld_last  = (i == n - 1);
            settle();
            check_eq("ld_wr_en", 64'(mem_wr_en), 64'd1);
            check_eq("ld_addr", 64'(mem_addr), 64'(i));
            check_eq("ld_wdata", 64'(mem_wdata), 64'(32'hC0DE_0000 + 32'(i)));
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic expect_stream(input string tag, input int first_pc, input int n);
        for (int k = 0; k < n; k++) begin
            int p;
            p = (first_pc + k) % (2 ** AW);
            check_eq({tag, "_valid"}, 64'(if_valid), 64'd1);
            check_eq({tag, "_pc"}, 64'(if_pc), 64'(p));
            check_eq({tag, "_instr"}, 64'(if_instr), 64'(exp_instr(p)));
            tick();
        end
    endtask

    initial begin
        int rd0;
        for (int i = 0; i < 2 ** AW; i++) imem[i] = 32'hA000_0000 + 32'(i);
        mem_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", 64'(state_o), 64'd0);
        check_eq("rst_ld_ready", 64'(ld_ready), 64'd1);
        check_eq("rst_if_valid", 64'(if_valid), 64'd0);
        check_eq("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check_eq("rst_wr_en", 64'(mem_wr_en), 64'd0);
        check_eq("rst_ovf", 64'(load_ovf), 64'd0);
        check_eq("rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Load 6 words, then first fetch latency
        if_ready = 1'b1;
        load_words(6);
        settle();
        check_eq("run_state", 64'(state_o), 64'd1);
        check_eq("run_ld_ready", 64'(ld_ready), 64'd0);
        check_eq("run_first_rd", 64'(mem_rd_en), 64'd1);
        check_eq("run_first_addr", 64'(mem_addr), 64'd0);
        check_eq("run_e0_valid", 64'(if_valid), 64'd0);
        tick();
        check_eq("run_e1_valid", 64'(if_valid), 64'd0);
        tick();

        // Streaming with no bubbles
        expect_stream("stream", 0, 10);

        // Stall: head held, only credit-limited reads
        if_ready = 1'b0;
        rd0 = rd_cnt;
        for (int j = 0; j < 8; j++) begin
            settle();
            check_eq("stall_valid", 64'(if_valid), 64'd1);
            check_eq("stall_pc", 64'(if_pc), 64'd10);
            check_eq("stall_instr", 64'(if_instr), 64'(exp_instr(10)));
            tick();
        end
        check_eq("stall_reads", 64'(rd_cnt - rd0), 64'd2);
        if_ready = 1'b1;
        expect_stream("release", 10, 8);

        // Redirect with 2 buffered + 1 in flight
        redirect_valid = 1'b1;
        redirect_pc    = 13'h100;
        settle();
        check_eq("redir_no_issue", 64'(mem_rd_en), 64'd0);
        check_eq("redir_head_pc", 64'(if_pc), 64'd18);
        tick();
        redirect_valid = 1'b0;
        settle();
        check_eq("redir_r1_valid", 64'(if_valid), 64'd0);
        check_eq("redir_r1_rd", 64'(mem_rd_en), 64'd1);
        check_eq("redir_r1_addr", 64'(mem_addr), 64'h100);
        tick();
        check_eq("redir_r2_valid", 64'(if_valid), 64'd0);
        tick();
        expect_stream("redir", 'h100, 3);

        // PC wrap at top of address space
        redirect_valid = 1'b1;
        redirect_pc    = 13'h1FFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        expect_stream("wrap", 'h1FFF, 3);

        // Halt mid-stream; HALT ignores redirect/halt/loader
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_eq("halt_valid", 64'(if_valid), 64'd0);
        check_eq("halt_state", 64'(state_o), 64'd2);
        check_eq("halt_rd", 64'(mem_rd_en), 64'd0);
        ld_valid = 1'b1;
        redirect_valid = 1'b1;
        halt_req = 1'b1;
        settle();
        check_eq("halt_wr_ignored", 64'(mem_wr_en), 64'd0);
        check_eq("halt_ld_ready", 64'(ld_ready), 64'd0);
        tick();
        ld_valid = 1'b0;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        check_eq("halt_stays", 64'(state_o), 64'd2);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        settle();
        check_eq("reload_state", 64'(state_o), 64'd0);
        check_eq("reload_ld_ready", 64'(ld_ready), 64'd1);
        load_words(2);
        tick();
        tick();
        check_eq("reload_first_pc", 64'(if_pc), 64'd0);
        check_eq("reload_first_valid", 64'(if_valid), 64'd1);

        // Asynchronous reset mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_state", 64'(state_o), 64'd0);
        check_eq("arst_valid", 64'(if_valid), 64'd0);
        check_eq("arst_ld_ready", 64'(ld_ready), 64'd1);
        check_eq("arst_rd", 64'(mem_rd_en), 64'd0);
        check_eq("arst_pc", 64'(if_pc), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Perf: 5 deliveries, 3 empty RUN cycles (E, E+1, post-redirect)
        load_words(6);
        tick();
        tick();
        expect_stream("perf", 0, 5);
        if_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 13'h40;
        tick();
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        settle();
        check_eq("perf_r1_valid", 64'(if_valid), 64'd0);
        tick();
        halt_req = 1'b0;
        check_eq("perf_halt_state", 64'(state_o), 64'd2);
`ifdef IMEM_PERF_CNT_EN
        check_eq("perf_fetch", 64'(perf_fetch_cnt), 64'd5);
        check_eq("perf_empty", 64'(perf_empty_cnt), 64'd3);
`else
        check_eq("perf_fetch_off", 64'(perf_fetch_cnt), 64'd0);
        check_eq("perf_empty_off", 64'(perf_empty_cnt), 64'd0);
`endif
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check_eq("perf_clear_fetch", 64'(perf_fetch_cnt), 64'd0);
        check_eq("perf_clear_empty", 64'(perf_empty_cnt), 64'd0);

        // Loader pointer wrap sets sticky load_ovf
        check_eq("ovf_before", 64'(load_ovf), 64'd0);
        ld_valid = 1'b1;
        for (int i = 0; i < 2 ** AW - 1; i++) begin
            ld_data = 32'(i);
            tick();
        end
        settle();
        check_eq("ovf_top_addr", 64'(mem_addr), 64'h1FFF);
        check_eq("ovf_not_yet", 64'(load_ovf), 64'd0);
        tick();
        settle();
        check_eq("ovf_set", 64'(load_ovf), 64'd1);
        check_eq("ovf_wrap_addr", 64'(mem_addr), 64'd0);
        ld_valid = 1'b0;
        tick();
        check_eq("ovf_sticky", 64'(load_ovf), 64'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
